cr16_ctrl_fsm: RTL and testbench

//  Multi-cycle control unit for the 16-bit core. Sits directly upstream of the register file.

---
 rtl/cr16_ctrl_fsm_if.sv | 35 +++
 rtl/cr16_ctrl_fsm.sv | 157 +++++++++++++++
 tb/tb_cr16_ctrl_fsm.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/cr16_ctrl_fsm_if.sv
// Control/bus bundle between the cr16 control FSM (master) and the datapath/memory side (slave).
interface cr16_ctrl_fsm_if #(
  parameter int WIDTH   = 16,
  parameter int REGBITS = 4
);
  logic [WIDTH-1:0]   instr;
  logic               mem_rdy;
  logic [4:0]         flags;
  logic               mem_req;
  logic               mem_we;
  logic               addr_sel;
  logic               pc_en;
  logic               pc_src;
  logic               regWrite;
  logic [REGBITS-1:0] sourceAddr;
  logic [REGBITS-1:0] destAddr;
  logic [3:0]         alu_op;
  logic               imm_sel;
  logic [WIDTH-1:0]   imm;
  logic               wb_sel;
  logic               flags_en;
  logic               illegal_op;

  modport master (
    input  instr, mem_rdy, flags,
    output mem_req, mem_we, addr_sel, pc_en, pc_src, regWrite, sourceAddr, destAddr,
           alu_op, imm_sel, imm, wb_sel, flags_en, illegal_op
  );

  modport slave (
    output instr, mem_rdy, flags,
    input  mem_req, mem_we, addr_sel, pc_en, pc_src, regWrite, sourceAddr, destAddr,
           alu_op, imm_sel, imm, wb_sel, flags_en, illegal_op
  );
endinterface

// File: rtl/cr16_ctrl_fsm.sv
// Multi-cycle control unit for the cr16 core: IR, field decode, FETCH/DECODE/EXEC/MEM/BRANCH/WB.
// Optional CTRL_TRAP_EN: illegal encodings park the FSM in HALT with illegal_op=1 until reset.
module cr16_ctrl_fsm #(
  parameter int WIDTH   = 16,
  parameter int REGBITS = 4
) (
  input  logic            clk,
  input  logic            reset,
  cr16_ctrl_fsm_if.master bus
);
  // state    | meaning
  // S_FETCH  | request instr at PC, wait for mem_rdy, load IR
  // S_DECODE | fields valid; PC+1 committed here so every output stays Moore
  // S_EXEC   | R/I ALU op; flags_en for ADD/SUB/CMP
  // S_MEM    | LOAD/STOR access at RF readData2, wait for mem_rdy
  // S_BRANCH | PC+disp if condition holds
  // S_WB     | single-cycle register write
  // S_HALT   | trap on illegal encoding (CTRL_TRAP_EN only)
  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_BRANCH, S_WB, S_HALT
  } state_t;

  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_ir;

  logic [3:0] w_op, w_ext, w_cond, w_alu_code;
  logic       w_is_alu, w_is_imm, w_is_load, w_is_stor, w_is_br, w_logical, w_taken;
  logic       w_mem_req, w_mem_we, w_addr_sel, w_pc_en, w_pc_src, w_reg_write;
  logic       w_imm_sel, w_wb_sel, w_flags_en, w_illegal;
  logic [3:0] w_alu_op;

  function automatic logic is_alu_code(input logic [3:0] c);
    case (c)
      4'b0001, 4'b0010, 4'b0011, 4'b0101, 4'b1001, 4'b1011, 4'b1101: is_alu_code = 1'b1;
      default: is_alu_code = 1'b0;
    endcase
  endfunction

  assign w_op       = r_ir[15:12];
  assign w_cond     = r_ir[11:8];
  assign w_ext      = r_ir[7:4];
  assign w_is_imm   = (w_op != 4'b0000) && is_alu_code(w_op);
  assign w_is_alu   = w_is_imm || ((w_op == 4'b0000) && is_alu_code(w_ext));
  assign w_alu_code = (w_op == 4'b0000) ? w_ext : w_op;
  assign w_is_load  = (w_op == 4'b0100) && (w_ext == 4'b0000);
  assign w_is_stor  = (w_op == 4'b0100) && (w_ext == 4'b0100);
  assign w_is_br    = (w_op == 4'b1100);
  assign w_logical  = w_is_imm && (w_op inside {4'b0001, 4'b0010, 4'b0011});

  // flags = {C,L,F,Z,N}
  always_comb begin
    case (w_cond)
      4'b0000: w_taken = bus.flags[1];
      4'b0001: w_taken = ~bus.flags[1];
      4'b0010: w_taken = bus.flags[4];
      4'b0011: w_taken = ~bus.flags[4];
      4'b0110: w_taken = bus.flags[0];
      4'b0111: w_taken = ~bus.flags[0];
      4'b1000: w_taken = bus.flags[2];
      4'b1001: w_taken = ~bus.flags[2];
      4'b1010: w_taken = bus.flags[3];
      4'b1011: w_taken = ~bus.flags[3];
      4'b1110: w_taken = 1'b1;
      default: w_taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_FETCH;
      r_ir    <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_FETCH && bus.mem_rdy) r_ir <= bus.instr;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_mem_req   = 1'b0;
    w_mem_we    = 1'b0;
    w_addr_sel  = 1'b0;
    w_pc_en     = 1'b0;
    w_pc_src    = 1'b0;
    w_reg_write = 1'b0;
    w_alu_op    = 4'b0000;
    w_imm_sel   = 1'b0;
    w_wb_sel    = 1'b0;
    w_flags_en  = 1'b0;
    w_illegal   = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_mem_req = 1'b1;
        if (bus.mem_rdy) w_next = S_DECODE;
      end
      S_DECODE: begin
        w_pc_en = 1'b1;
        if (w_is_alu)                    w_next = S_EXEC;
        else if (w_is_load || w_is_stor) w_next = S_MEM;
        else if (w_is_br)                w_next = S_BRANCH;
        else begin
`ifdef CTRL_TRAP_EN
          w_next = S_HALT;
`else
          w_next = S_FETCH;
`endif
        end
      end
      S_EXEC: begin
        w_alu_op   = w_alu_code;
        w_imm_sel  = w_is_imm;
        w_flags_en = w_alu_code inside {4'b0101, 4'b1001, 4'b1011};
        w_next     = (w_alu_code == 4'b1011) ? S_FETCH : S_WB;
      end
      S_MEM: begin
        w_mem_req  = 1'b1;
        w_addr_sel = 1'b1;
        w_mem_we   = w_is_stor;
        if (bus.mem_rdy) w_next = w_is_stor ? S_FETCH : S_WB;
      end
      S_BRANCH: begin
        w_pc_en  = w_taken;
        w_pc_src = w_taken;
        w_next   = S_FETCH;
      end
      S_WB: begin
        w_reg_write = 1'b1;
        w_wb_sel    = w_is_load;
        w_next      = S_FETCH;
      end
`ifdef CTRL_TRAP_EN
      S_HALT: begin
        w_illegal = 1'b1;
        w_next    = S_HALT;
      end
`endif
      default: w_next = S_FETCH;
    endcase
  end

  // Strobes are masked while reset is held so an aborted instruction commits nothing.
  assign bus.mem_req    = w_mem_req   & ~reset;
  assign bus.mem_we     = w_mem_we    & ~reset;
  assign bus.pc_en      = w_pc_en     & ~reset;
  assign bus.regWrite   = w_reg_write & ~reset;
  assign bus.flags_en   = w_flags_en  & ~reset;
  assign bus.illegal_op = w_illegal   & ~reset;
  assign bus.addr_sel   = w_addr_sel;
  assign bus.pc_src     = w_pc_src;
  assign bus.alu_op     = w_alu_op;
  assign bus.imm_sel    = w_imm_sel;
  assign bus.wb_sel     = w_wb_sel;
  assign bus.sourceAddr = r_ir[REGBITS-1:0];
  assign bus.destAddr   = r_ir[8 +: REGBITS];
  assign bus.imm        = w_logical ? {{(WIDTH-8){1'b0}}, r_ir[7:0]}
                                    : {{(WIDTH-8){r_ir[7]}}, r_ir[7:0]};
endmodule

// File: tb/tb_cr16_ctrl_fsm.sv
// Directed bench for cr16_ctrl_fsm: per-cycle strobe vectors queued ahead and popped each cycle.
module tb_cr16_ctrl_fsm;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cr16_ctrl_fsm_if bus_if ();
  cr16_ctrl_fsm dut (.clk(clk), .reset(reset), .bus(bus_if));

  // {mem_req, mem_we, addr_sel, pc_en, pc_src, regWrite, imm_sel, wb_sel, flags_en, illegal_op}
  localparam logic [9:0] V_Z   = 10'b00_0000_0000;
  localparam logic [9:0] V_F   = 10'b10_0000_0000;
  localparam logic [9:0] V_D   = 10'b00_0100_0000;
  localparam logic [9:0] V_EXR = 10'b00_0000_0010;
  localparam logic [9:0] V_EXI = 10'b00_0000_1010;
  localparam logic [9:0] V_EXL = 10'b00_0000_1000;
  localparam logic [9:0] V_WB  = 10'b00_0001_0000;
  localparam logic [9:0] V_ML  = 10'b10_1000_0000;
  localparam logic [9:0] V_MS  = 10'b11_1000_0000;
  localparam logic [9:0] V_WBL = 10'b00_0001_0100;
  localparam logic [9:0] V_BT  = 10'b00_0110_0000;
  localparam logic [9:0] V_H   = 10'b00_0000_0001;

  typedef struct {
    string      tag;
    logic [9:0] vec;
  } sb_t;
  sb_t sbq[$];

  int ncomp = 0;
  int nfail = 0;

  logic [3:0]  s_src, s_dst, s_alu;
  logic [15:0] s_imm;

  function automatic logic [9:0] obs_vec();
    return {bus_if.mem_req, bus_if.mem_we, bus_if.addr_sel, bus_if.pc_en, bus_if.pc_src,
            bus_if.regWrite, bus_if.imm_sel, bus_if.wb_sel, bus_if.flags_en, bus_if.illegal_op};
  endfunction

  task automatic exp(input string tag, input logic [9:0] v);
    sb_t e;
    e.tag = tag;
    e.vec = v;
    sbq.push_back(e);
  endtask

  task automatic cyc(input logic rdy, input logic rst);
    sb_t e;
    logic [9:0] o;
    bus_if.mem_rdy = rdy;
    reset = rst;
    @(negedge clk);
    o     = obs_vec();
    s_src = bus_if.sourceAddr;
    s_dst = bus_if.destAddr;
    s_alu = bus_if.alu_op;
    s_imm = bus_if.imm;
    ncomp++;
    if (sbq.size() == 0) begin
      nfail++;
      $error("FAIL sb_empty observed=%b required=<queued entry>", o);
    end else begin
      e = sbq.pop_front();
      assert (o === e.vec) else begin
        nfail++;
        $error("FAIL %s observed=%b required=%b", e.tag, o, e.vec);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] req);
    ncomp++;
    assert (obs === req) else begin
      nfail++;
      $error("FAIL %s observed=%h required=%h", tag, obs, req);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset          = 1'b1;
    bus_if.mem_rdy = 1'b0;
    bus_if.instr   = 16'h0000;
    bus_if.flags   = 5'b00000;

    // reset hold, then idle FETCH with IR cleared
    exp("rst_hold", V_Z);  cyc(1'b1, 1'b1);
    exp("rst_hold2", V_Z); cyc(1'b0, 1'b1);
    exp("rst_fetch", V_F); cyc(1'b0, 1'b0);
    chk("rst_dst", {12'h0, s_dst}, 16'h0000);
    chk("rst_imm", s_imm, 16'h0000);
    exp("rst_fetch_wait", V_F); cyc(1'b0, 1'b0);

    // ADD R3,R4
    bus_if.instr = 16'h0354;
    exp("add_f", V_F);  cyc(1'b1, 1'b0);
    exp("add_d", V_D);  cyc(1'b1, 1'b0);
    chk("add_dst", {12'h0, s_dst}, 16'h0003);
    chk("add_src", {12'h0, s_src}, 16'h0004);
    exp("add_ex", V_EXR); cyc(1'b1, 1'b0);
    chk("add_alu", {12'h0, s_alu}, 16'h0005);
    exp("add_wb", V_WB); cyc(1'b1, 1'b0);

    // ADDI R2,#-1
    bus_if.instr = 16'h52FF;
    exp("addi_f", V_F);  cyc(1'b1, 1'b0);
    exp("addi_d", V_D);  cyc(1'b1, 1'b0);
    chk("addi_imm", s_imm, 16'hFFFF);
    exp("addi_ex", V_EXI); cyc(1'b1, 1'b0);
    exp("addi_wb", V_WB);  cyc(1'b1, 1'b0);

    // ANDI R2,#80: zero-extended, no flags
    bus_if.instr = 16'h1280;
    exp("andi_f", V_F);  cyc(1'b1, 1'b0);
    exp("andi_d", V_D);  cyc(1'b1, 1'b0);
    chk("andi_imm", s_imm, 16'h0080);
    exp("andi_ex", V_EXL); cyc(1'b1, 1'b0);
    chk("andi_alu", {12'h0, s_alu}, 16'h0001);
    exp("andi_wb", V_WB);  cyc(1'b1, 1'b0);

    // CMP R1,R2: back to FETCH without WB
    bus_if.instr = 16'h01B2;
    exp("cmp_f", V_F);   cyc(1'b1, 1'b0);
    exp("cmp_d", V_D);   cyc(1'b1, 1'b0);
    exp("cmp_ex", V_EXR); cyc(1'b1, 1'b0);
    chk("cmp_alu", {12'h0, s_alu}, 16'h000B);

    // LOAD R5,[R6] with 3 wait cycles in MEM
    bus_if.instr = 16'h4506;
    exp("ld_f", V_F);  cyc(1'b1, 1'b0);
    exp("ld_d", V_D);  cyc(1'b0, 1'b0);
    chk("ld_dst", {12'h0, s_dst}, 16'h0005);
    chk("ld_src", {12'h0, s_src}, 16'h0006);
    for (int i = 0; i < 3; i++) begin
      exp("ld_mem_wait", V_ML); cyc(1'b0, 1'b0);
    end
    exp("ld_mem_done", V_ML); cyc(1'b1, 1'b0);
    exp("ld_wb", V_WBL);      cyc(1'b0, 1'b0);

    // STOR R7,[R6]
    bus_if.instr = 16'h4746;
    exp("st_f", V_F);   cyc(1'b1, 1'b0);
    exp("st_d", V_D);   cyc(1'b1, 1'b0);
    exp("st_mem", V_MS); cyc(1'b1, 1'b0);
    exp("st_back", V_F); cyc(1'b0, 1'b0);

    // BEQ +4, Z=1 then Z=0; UC always; code 0100 never
    bus_if.instr = 16'hC004;
    bus_if.flags = 5'b00010;
    exp("beq_t_f", V_F);  cyc(1'b1, 1'b0);
    exp("beq_t_d", V_D);  cyc(1'b1, 1'b0);
    exp("beq_t_br", V_BT); cyc(1'b1, 1'b0);
    bus_if.flags = 5'b11101;
    exp("beq_n_f", V_F);  cyc(1'b1, 1'b0);
    exp("beq_n_d", V_D);  cyc(1'b1, 1'b0);
    exp("beq_n_br", V_Z); cyc(1'b1, 1'b0);
    bus_if.instr = 16'hCE04;
    bus_if.flags = 5'b00000;
    exp("buc_f", V_F);  cyc(1'b1, 1'b0);
    exp("buc_d", V_D);  cyc(1'b1, 1'b0);
    exp("buc_br", V_BT); cyc(1'b1, 1'b0);
    bus_if.instr = 16'hC404;
    bus_if.flags = 5'b11111;
    exp("bnv_f", V_F);  cyc(1'b1, 1'b0);
    exp("bnv_d", V_D);  cyc(1'b1, 1'b0);
    exp("bnv_br", V_Z); cyc(1'b1, 1'b0);
    bus_if.flags = 5'b00000;

    // reset during EXEC of ADD aborts: no regWrite, IR cleared
    bus_if.instr = 16'h0354;
    exp("abort_f", V_F);   cyc(1'b1, 1'b0);
    exp("abort_d", V_D);   cyc(1'b1, 1'b0);
    exp("abort_ex", V_Z);  cyc(1'b1, 1'b1);
    exp("abort_f2", V_F);  cyc(1'b0, 1'b0);
    chk("abort_dst", {12'h0, s_dst}, 16'h0000);
    chk("abort_src", {12'h0, s_src}, 16'h0000);
    exp("abort_f3", V_F);  cyc(1'b0, 1'b0);

    // reset wins over mem_rdy in FETCH
    exp("rstprio_f", V_Z); cyc(1'b1, 1'b1);
    exp("rstprio_f2", V_F); cyc(1'b0, 1'b0);
    chk("rstprio_dst", {12'h0, s_dst}, 16'h0000);

    // illegal encoding
    bus_if.instr = 16'hF000;
    exp("ill_f", V_F); cyc(1'b1, 1'b0);
    exp("ill_d", V_D); cyc(1'b1, 1'b0);
`ifdef CTRL_TRAP_EN
    for (int i = 0; i < 3; i++) begin
      exp("ill_halt", V_H); cyc(1'b1, 1'b0);
    end
    exp("ill_rst", V_Z);   cyc(1'b0, 1'b1);
    exp("ill_after", V_F); cyc(1'b0, 1'b0);
`else
    exp("ill_nop_f", V_F);  cyc(1'b0, 1'b0);
    exp("ill_nop_f2", V_F); cyc(1'b0, 1'b0);
`endif

    ncomp++;
    assert (sbq.size() == 0) else begin
      nfail++;
      $error("FAIL sb_leftover observed=%0d required=0", sbq.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end
endmodule
